// File: rtl/down_counter_pkg.sv
// Shared definitions for the counter family: FSM state encodings and default widths.
package down_counter_pkg;

    // Default counter / load-value width in bits.
    localparam int unsigned DefaultWidth = 4;

    // Counter FSM state encoding, shared with the up_counter family.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } cnt_state_e;

endpackage

// File: rtl/down_counter.sv
// Loadable down-counter with terminal-count pulse and optional auto-reload.
// RELOAD=0 stops in DONE at zero; RELOAD=1 restarts from the last loaded value.
module down_counter
    import down_counter_pkg::*;
#(
    parameter int unsigned WIDTH  = DefaultWidth,
    parameter int unsigned RELOAD = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] val,
    input  logic             load,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             R,
    output logic             busy
);

    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    cnt_state_e       state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] reload_q;
    logic             r_q;

    // FSM, counter, reload register and terminal pulse; reset dominates, then load, then en.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            count_q  <= '0;
            reload_q <= '0;
            r_q      <= 1'b0;
        end else if (load) begin
            count_q  <= val;
            reload_q <= val;
            if (val == '0) begin
                // Zero load terminates immediately.
                state_q <= StDone;
                r_q     <= 1'b1;
            end else begin
                state_q <= StRun;
                r_q     <= 1'b0;
            end
        end else begin
            r_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    count_q <= '0;
                end
                StRun: begin
                    if (en) begin
                        // count_q of 0 cannot occur in RUN; treated as terminal to rule out wrap.
                        if (count_q <= One) begin
                            r_q <= 1'b1;
                            if (RELOAD != 0) begin
                                count_q <= reload_q;
                            end else begin
                                count_q <= '0;
                                state_q <= StDone;
                            end
                        end else begin
                            count_q <= count_q - One;
                        end
                    end
                end
                StDone: begin
                    count_q <= '0;
                end
                default: begin
                    state_q <= StIdle;
                    count_q <= '0;
                end
            endcase
        end
    end

    // Outputs come straight from registers; busy decodes the state with no added delay.
    always_comb begin
        count = count_q;
        R     = r_q;
        busy  = (state_q == StRun);
    end

endmodule
